fifo_wr_arbiter: RTL and testbench

- Shares the single write port of one `fifo` instance (B-bit words, 2**W entries) between N requesters using round-robin arbitration.
- Registers the FIFO write strobe and data for timing.
- Tracks FIFO occupancy with an internal credit counter, fed by the consumer's accepted pops. This guarantees the FIFO is never written while full and removes the one-cycle lag of the FIFO's `full` flag.
- Sits between the producer blocks and the FIFO. The FIFO's `rd` side stays with the consumer.

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO-write signal bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int B = 8,
    parameter int W = 4,
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N*B-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           fifo_pop;
    logic           fifo_wr;
    logic [B-1:0]   fifo_wr_data;
    logic [W:0]     credits;

    modport master (
        output req, req_data, fifo_pop,
        input  gnt, fifo_wr, fifo_wr_data, credits
    );

    modport slave (
        input  req, req_data, fifo_pop,
        output gnt, fifo_wr, fifo_wr_data, credits
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port, credit-tracked occupancy
// Define FIFO_ARB_BURST_EN to let a granted requester keep the port for up to MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int B         = 8,
    parameter int W         = 4,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int         PW           = (N > 1) ? $clog2(N) : 1;
    localparam logic [W:0] FULL_CREDITS = {1'b1, {W{1'b0}}};

    logic [W:0]    credits_q, credits_n;
    logic [W+1:0]  credit_sum;
    logic [PW-1:0] ptr_q, ptr_n, sel, owner_sel;
    logic [PW:0]   cand;
    logic          gnt_any, owner_keep, wr_q;
    logic [B-1:0]  wr_data_q;

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] owner_q, owner_n;
    logic [CW-1:0] cnt_q, cnt_n;

    assign owner_keep = (state_q == BURST) && bus.req[owner_q];
    assign owner_sel  = owner_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            cnt_q   <= cnt_n;
        end
    end

    // With no credits nothing is granted, so the FSM holds in place.
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        cnt_n   = cnt_q;
        if (credits_q != '0) begin
            if (owner_keep) begin
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == CW'(MAX_BURST - 1)) begin
                    state_n = ARB;
                end
            end else if (gnt_any && (MAX_BURST > 1)) begin
                state_n = BURST;
                owner_n = sel;
                cnt_n   = CW'(1);
            end else begin
                state_n = ARB;
            end
        end
    end
`else
    assign owner_keep = 1'b0;
    assign owner_sel  = '0;

    if (MAX_BURST < 1) begin : g_max_burst_unused
    end
`endif

    // No word is accepted while reset is held: it would be dropped anyway.
    always_comb begin
        gnt_any = 1'b0;
        sel     = ptr_q;
        cand    = '0;
        if (!reset && (credits_q != '0)) begin
            if (owner_keep) begin
                gnt_any = 1'b1;
                sel     = owner_sel;
            end else begin
                for (int k = 0; k < N; k++) begin
                    cand = {1'b0, ptr_q} + (PW+1)'(k);
                    if (cand >= (PW+1)'(N)) begin
                        cand = cand - (PW+1)'(N);
                    end
                    if (!gnt_any && bus.req[cand[PW-1:0]]) begin
                        gnt_any = 1'b1;
                        sel     = cand[PW-1:0];
                    end
                end
            end
        end
    end

    assign ptr_n      = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
    assign credit_sum = {1'b0, credits_q} + (W+2)'(bus.fifo_pop) - (W+2)'(gnt_any);
    // A pop at full credits is a consumer error; saturate rather than wrap.
    assign credits_n  = (credit_sum > {1'b0, FULL_CREDITS}) ? FULL_CREDITS : credit_sum[W:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q <= FULL_CREDITS;
            ptr_q     <= '0;
            wr_q      <= 1'b0;
            wr_data_q <= '0;
        end else begin
            credits_q <= credits_n;
            wr_q      <= gnt_any;
            if (gnt_any) begin
                ptr_q     <= ptr_n;
                wr_data_q <= bus.req_data[sel*B +: B];
            end
        end
    end

    assign bus.gnt          = gnt_any ? (N'(1) << sel) : '0;
    assign bus.fifo_wr      = wr_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.credits      = credits_q;

`ifdef SIM
    assert property (@(posedge clk) disable iff (reset) !(bus.fifo_pop && (credits_q == FULL_CREDITS)));
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int B     = 8;
    localparam int W     = 4;
    localparam int N     = 4;
    localparam int MAXB  = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] DATA = 32'h44332211;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_wr_arbiter_if #(.B(B), .W(W), .N(N)) bus ();

    fifo_wr_arbiter #(.B(B), .W(W), .N(N), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO behaviour: stores words written by the arbiter, removes on pop.
    logic [7:0] fifo_q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q.delete();
        end else begin
            if (bus.fifo_wr) check("fifo_wr_not_full", 32'(fifo_q.size() < DEPTH), 32'd1);
            if (bus.fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (bus.fifo_wr) fifo_q.push_back(bus.fifo_wr_data);
        end
    end

    // Reference model: credits, rotating priority, optional burst ownership.
    int         m_cred, m_ptr, m_owner, m_cnt;
    bit         m_burst, m_wr;
    logic [7:0] m_data;
    logic [7:0] exp_words[$];

    function automatic logic [7:0] slice(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    task automatic model_reset();
        m_cred = DEPTH; m_ptr = 0; m_owner = 0; m_cnt = 0;
        m_burst = 0; m_wr = 0; m_data = 8'h00;
        exp_words.delete();
    endtask

    function automatic int model_pick(input logic [3:0] r);
        if (m_cred == 0) return -1;
`ifdef FIFO_ARB_BURST_EN
        if (m_burst && r[m_owner]) return m_owner;
`endif
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step(input logic [31:0] d, input bit pop, input int g);
        m_wr = (g >= 0);
        if (g >= 0) begin
            m_data = slice(d, g);
            m_ptr  = (g + 1) % N;
        end
`ifdef FIFO_ARB_BURST_EN
        if (m_cred > 0) begin
            if (g >= 0 && m_burst && g == m_owner) begin
                m_cnt++;
                if (m_cnt == MAXB) m_burst = 0;
            end else if (g >= 0) begin
                m_owner = g; m_cnt = 1; m_burst = (MAXB > 1);
            end else begin
                m_burst = 0;
            end
        end
`endif
        m_cred = m_cred - ((g >= 0) ? 1 : 0) + (pop ? 1 : 0);
        if (m_cred > DEPTH) m_cred = DEPTH;
    endtask

    task automatic drive(input logic [3:0] r, input logic [31:0] d, input bit p);
        bus.req = r; bus.req_data = d; bus.fifo_pop = p;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [4:0] cred;
        logic       wr;
        logic [7:0] data;
    } vec_t;

    vec_t       tbl[10];
    int         rr_seq[6];
    int         bs_seq[9];
    logic [3:0] r;
    logic [31:0] d;
    bit         p;
    int         g;

    initial begin
        tbl[0] = '{4'b0000, 4'b0000, 5'd16, 1'b0, 8'h00};
        tbl[1] = '{4'b0100, 4'b0100, 5'd16, 1'b0, 8'h00};
        tbl[2] = '{4'b1011, 4'b1000, 5'd15, 1'b1, 8'h33};
        tbl[3] = '{4'b0011, 4'b0001, 5'd14, 1'b1, 8'h44};
        tbl[4] = '{4'b0110, 4'b0010, 5'd13, 1'b1, 8'h11};
        tbl[5] = '{4'b0001, 4'b0001, 5'd12, 1'b1, 8'h22};
        tbl[6] = '{4'b1100, 4'b0100, 5'd11, 1'b1, 8'h11};
        tbl[7] = '{4'b0000, 4'b0000, 5'd10, 1'b1, 8'h33};
        tbl[8] = '{4'b1010, 4'b1000, 5'd10, 1'b0, 8'h33};
        tbl[9] = '{4'b0110, 4'b0010, 5'd9,  1'b1, 8'h44};
`ifdef FIFO_ARB_BURST_EN
        rr_seq = '{0, 0, 0, 0, 1, 1};
        bs_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
        rr_seq = '{0, 1, 2, 3, 0, 1};
        bs_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
        drive(4'b0000, 32'h0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("reset_gnt", bus.gnt, 0);
        check("reset_wr", bus.fifo_wr, 0);
        check("reset_wr_data", bus.fifo_wr_data, 0);
        check("reset_credits", bus.credits, 16);

        // Table-driven grant/credit/data vectors from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].req, DATA, 1'b0);
            @(negedge clk);
            check("tbl_gnt", bus.gnt, 32'(tbl[i].gnt));
            check("tbl_credits", bus.credits, 32'(tbl[i].cred));
            check("tbl_wr", bus.fifo_wr, 32'(tbl[i].wr));
            check("tbl_wr_data", bus.fifo_wr_data, 32'(tbl[i].data));
            next();
        end

        // Asynchronous reset in the middle of traffic, then idle.
        do_reset();
        drive(4'b1111, DATA, 1'b0);
        next();
        next();
        #2 reset = 1'b1;
        #1;
        check("midrst_gnt", bus.gnt, 0);
        check("midrst_wr", bus.fifo_wr, 0);
        check("midrst_credits", bus.credits, 16);
        drive(4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_wr", bus.fifo_wr, 0);
            check("idle_gnt", bus.gnt, 0);
            next();
        end

        // Fill to full from a single requester.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(4'b0001, 32'(c < 16 ? c : 16), 1'b0);
            @(negedge clk);
            check("fill_gnt", bus.gnt, (c < 16) ? 32'd1 : 32'd0);
            check("fill_credits", bus.credits, 32'(c < 16 ? 16 - c : 0));
            next();
        end
        check("fill_occupancy", fifo_q.size(), 16);

        // Pop at zero credits: grant waits one cycle.
        check("popz_readback", fifo_q[0], 8'h00);
        drive(4'b0100, 32'h00A50000, 1'b1);
        @(negedge clk);
        check("popz_gnt_stall", bus.gnt, 0);
        check("popz_credits0", bus.credits, 0);
        next();
        drive(4'b0100, 32'h00A50000, 1'b0);
        @(negedge clk);
        check("popz_gnt_next", bus.gnt, 32'b0100);
        check("popz_credits1", bus.credits, 1);
        next();
        drive(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        check("popz_credits_after", bus.credits, 0);
        next();
        next();
        for (int k = 1; k <= 16; k++) begin
            check("readback", fifo_q.size() > 0 ? 32'(fifo_q[0]) : 32'hDEAD, (k < 16) ? 32'(k) : 32'hA5);
            drive(4'b0000, 32'h0, 1'b1);
            next();
        end
        drive(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        check("drain_credits", bus.credits, 16);
        check("drain_empty", fifo_q.size(), 0);
        next();

        // Round-robin over all four requesters.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'b1111, DATA, 1'b0);
            @(negedge clk);
            check("rr_gnt", bus.gnt, 32'(4'b0001 << rr_seq[k]));
            if (k > 0) begin
                check("rr_wr", bus.fifo_wr, 1);
                check("rr_data", bus.fifo_wr_data, 32'(slice(DATA, rr_seq[k-1])));
            end
            next();
        end
        drive(4'b0000, DATA, 1'b0);
        @(negedge clk);
        check("rr_data_last", bus.fifo_wr_data, 32'(slice(DATA, rr_seq[5])));
        next();

        // Grant and pop in the same cycle at credits=5.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(4'b0001, 32'h5C, 1'b0);
            next();
        end
        drive(4'b0000, 32'h0, 1'b0);
        next(); next(); next();
        @(negedge clk);
        check("sim_credits_pre", bus.credits, 5);
        check("sim_occ_pre", fifo_q.size(), 11);
        next();
        check("sim_readback", fifo_q[0], 8'h5C);
        drive(4'b0001, 32'h5C, 1'b1);
        @(negedge clk);
        check("sim_gnt", bus.gnt, 1);
        check("sim_credits_same", bus.credits, 5);
        next();
        drive(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        check("sim_credits_after", bus.credits, 5);
        next();
        @(negedge clk);
        check("sim_occ_after", fifo_q.size(), 11);
        next();

        // Two requesters held continuously: burst vs plain alternation.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(4'b0011, DATA, 1'b0);
            @(negedge clk);
            check("burst_gnt", bus.gnt, 32'(4'b0001 << bs_seq[k]));
            next();
        end

        // Randomized traffic against the reference model.
        do_reset();
        r = 4'b0000;
        d = 32'h0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!r[i] && $urandom_range(0, 2) == 0) begin
                    r[i] = 1'b1;
                    d[i*8 +: 8] = 8'($urandom);
                end
            end
            p = (fifo_q.size() > 0) && ($urandom_range(0, 3) < 32'((cyc / 100) % 4));
            if (p) begin
                check("rand_readback", fifo_q[0], exp_words.size() > 0 ? 32'(exp_words[0]) : 32'hDEAD);
                if (exp_words.size() > 0) void'(exp_words.pop_front());
            end
            drive(r, d, p);
            g = model_pick(r);
            @(negedge clk);
            check("rand_gnt", bus.gnt, (g < 0) ? 32'd0 : (32'd1 << g));
            check("rand_credits", bus.credits, 32'(m_cred));
            check("rand_wr", bus.fifo_wr, 32'(m_wr));
            check("rand_wr_data", bus.fifo_wr_data, 32'(m_data));
            if (g >= 0) begin
                exp_words.push_back(slice(d, g));
                r[g] = 1'b0;
            end
            model_step(d, p, g);
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
